// File: rtl/dcnt_pkg.sv
// Shared constants and state encoding for the dcnt16 down-counter/timer.
package dcnt_pkg;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/decr16.sv
// Combinational 16-bit decrementer built from four nibble slices; a nibble
// decrements only when every lower nibble is zero (the borrow ripples through).
module decr16
  import dcnt_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             bw
);

  logic [NIBBLES:0] lower_zero;

  assign lower_zero[0] = 1'b1;

  for (genvar j = 0; j < NIBBLES; j++) begin : g_decr4
    logic [3:0] nib;
    logic       zero;
    assign nib                 = in[4*j +: 4];
    assign zero                = (nib == 4'd0);
    assign lower_zero[j+1]     = lower_zero[j] & zero;
    assign out[4*j +: 4]       = lower_zero[j] ? (nib - 4'd1) : nib;
  end

  // Borrow out: the whole input was zero, so the result wrapped to all ones.
  assign bw = lower_zero[NIBBLES];

endmodule

// File: rtl/dcnt16.sv
// Loadable 16-bit down-counter/timer with terminal-count pulse and auto-reload.
// Handshake: a load is taken on a rising edge when ld_valid & ld_ready.
module dcnt16
  import dcnt_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [W-1:0] ld_value,
  input  logic         ld_auto,
  input  logic         en,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         tc
);

  if (W != 16) begin : g_bad_width
    $error("dcnt16 supports only a 16-bit counter");
  end

  state_t       state;
  logic [W-1:0] reload_q;
  logic         auto_q;
  logic [W-1:0] dec;
  logic         bw;
  logic         dec_zero;
  logic         accept;
  logic         ld_zero;

  decr16 u_decr16 (
    .in  (count),
    .out (dec),
    .bw  (bw)
  );

  // Expiry is detected on the decrementer result rather than comparing count to 1.
  assign dec_zero = (dec == '0);
  assign ld_zero  = (ld_value == '0);
  assign ld_ready = (state != RUN) & ~abort;
  assign accept   = ld_valid & ld_ready;
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      tc       <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
    end else if (accept) begin
      count    <= ld_value;
      reload_q <= ld_value;
      auto_q   <= ld_auto & ~ld_zero;
      state    <= ld_zero ? DONE : RUN;
      tc       <= ld_zero;
    end else begin
      tc <= 1'b0;
      if (state == RUN && en) begin
        if (dec_zero) begin
          tc <= 1'b1;
          if (auto_q) begin
            count <= reload_q;
          end else begin
            count <= '0;
            state <= DONE;
          end
        end else begin
          count <= dec;
        end
      end
    end
  end

  // count is never zero while running, so the decrementer must never borrow there.
  assert property (@(posedge clk) disable iff (!rst_n) (state == RUN) |-> !bw);

endmodule

// File: tb/tb_dcnt16.sv
// Self-checking bench for dcnt16: directed scenarios plus random traffic scored
// against an enabled-tick model, and an exhaustive check of decr16.
module tb_dcnt16;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_value = '0;
  logic        ld_auto = 1'b0;
  logic        en = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] count;
  logic        busy;
  logic        tc;

  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        d_bw;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // Model: a load of n plus the number of enabled ticks since that load.
  bit m_active = 0;
  bit m_auto   = 0;
  int m_n      = 0;
  int m_t      = 0;

  dcnt16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_value (ld_value),
    .ld_auto  (ld_auto),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .tc       (tc)
  );

  decr16 u_dec (
    .in  (d_in),
    .out (d_out),
    .bw  (d_bw)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_running();
    return m_active && m_n != 0 && (m_auto || m_t < m_n);
  endfunction

  function automatic int m_count();
    if (!m_active) return 0;
    if (m_auto && m_n != 0) return m_n - (m_t % m_n);
    return (m_t >= m_n) ? 0 : m_n - m_t;
  endfunction

  // driver: one clock cycle of stimulus, with the predicted result queued
  task automatic cycle(input bit v, input int val, input bit au, input bit e, input bit ab);
    bit exp_tc;
    @(negedge clk);
    ld_valid = v;
    ld_value = val[15:0];
    ld_auto  = au;
    en       = e;
    abort    = ab;
    #1;
    chk("ld_ready", ld_ready, !m_running() && !ab);
    exp_tc = 0;
    if (ab) begin
      m_active = 0;
      m_n = 0;
      m_t = 0;
    end else if (v && !m_running()) begin
      m_active = 1;
      m_n = val & 16'hffff;
      m_auto = au && (m_n != 0);
      m_t = 0;
      exp_tc = (m_n == 0);
    end else if (m_running() && e) begin
      m_t++;
      exp_tc = m_auto ? (m_t % m_n == 0) : (m_t == m_n);
    end
    exp_q.push_back({m_count()[15:0], exp_tc, m_running()});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({count, tc, busy} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: count=%h tc=%b busy=%b expected count=%h tc=%b busy=%b",
                   count, tc, busy, e[17:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int dec_fail_prints;
    bit rv, ra, re, rb;
    int rval;

    // decr16 exhaustive
    dec_fail_prints = 0;
    for (int i = 0; i < 65536; i++) begin
      d_in = i[15:0];
      #1;
      n_tests++;
      if (d_out !== 16'(i - 1) || d_bw !== (i == 0)) begin
        n_fail++;
        if (dec_fail_prints < 10) begin
          dec_fail_prints++;
          $display("FAIL decr16: in=%h out=%h bw=%b expected out=%h bw=%b",
                   d_in, d_out, d_bw, 16'(i - 1), (i == 0));
        end
      end
    end

    // reset state, handshakes ignored while in reset
    ld_valid = 1'b1;
    ld_value = 16'd9;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ld_ready, 1);
    abort = 1'b1;
    #1;
    chk("rst_ready_abort", ld_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    ld_valid = 1'b0;
    rst_n = 1'b1;

    // one-shot 5
    cycle(1, 5, 0, 1, 0);
    idle_cycles(8);
    // borrow chains
    cycle(1, 16'h1000, 0, 1, 0);
    idle_cycles(2);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'h0100, 0, 1, 0);
    idle_cycles(2);
    cycle(0, 0, 0, 0, 1);
    // auto-reload 3, then abort, then auto with 0
    cycle(1, 3, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 7, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 0);
    idle_cycles(3);
    // auto-reload with period 1
    cycle(1, 1, 1, 1, 0);
    idle_cycles(4);
    cycle(0, 0, 0, 1, 1);
    // pause
    cycle(1, 4, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    idle_cycles(4);
    // abort in the expiry cycle
    cycle(1, 2, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    // load with abort is not accepted
    cycle(1, 9, 0, 1, 1);
    idle_cycles(1);
    // load 7 in the DONE/tc cycle
    cycle(1, 3, 0, 1, 0);
    idle_cycles(3);
    cycle(1, 7, 0, 1, 0);
    idle_cycles(2);
    cycle(0, 0, 0, 1, 1);

    // asynchronous reset mid-RUN
    cycle(1, 5, 0, 1, 0);
    idle_cycles(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tc", tc, 0);
    exp_q.delete();
    m_active = 0;
    m_n = 0;
    m_t = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2, 0, 1, 0);
    idle_cycles(4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 3) == 0);
      rval = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 65535));
      ra = $urandom_range(0, 1);
      re = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 40) == 0);
      cycle(rv, rval, ra, re, rb);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcnt16.md
# dcnt16

Loadable 16-bit down-counter/timer, the decrementing counterpart of the team's 16-bit nibble-carry-select incrementer. A new count is accepted over a valid/ready handshake and decremented once per enabled cycle. The block pulses a terminal-count strobe on expiry and can auto-reload for periodic operation. It sits beside the incrementer-based up-counters in the timer/sequencer area.

## Interface

- WIDTH, 16, counter width; fixed at 16 (4 nibbles), elaborating any other value is an error
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load request
- ld_ready  out  1  load can be accepted this cycle
- ld_value  in  16  initial count
- ld_auto  in  1  auto-reload mode for this load
- en  in  1  count enable; low pauses counting in RUN
- abort  in  1  cancel current operation
- count  out  16  current count register
- busy  out  1  state == RUN
- tc  out  1  terminal-count pulse, one cycle, registered

## Operation

- States: IDLE, RUN, DONE.
- ld_ready = (state != RUN) & ~abort. It is combinational and does not depend on ld_valid.
- Accept occurs when ld_valid & ld_ready at a rising edge. The block captures ld_value into count and reload_q, and captures auto_q = ld_auto & (ld_value != 0).
- Accept with ld_value != 0: enter RUN.
- Accept with ld_value == 0: enter DONE with count = 0 and tc = 1 on the next cycle. This is immediate expiry.
- RUN, en = 0: count holds and tc = 0.
- RUN, en = 1, count != 1: count <= count - 1.
- RUN, en = 1, count == 1, expiry:
  - One-shot: count <= 0, state <= DONE, tc <= 1.
  - Auto-reload: count <= reload_q, stay in RUN, tc <= 1. The period is reload_q enabled cycles.
- DONE: count holds 0. Behaves like IDLE for loads.
- abort, any state: next state IDLE, count <= 0, tc <= 0. abort has priority over expiry and over load, so an expiry coincident with abort produces no tc.
- Auto-reload can only be changed with abort followed by a new load, because ld_ready is low throughout RUN.
- Arithmetic: the decrement is modulo 2^16 through decr16. The borrow output (in == 0) must never assert while in RUN; assert this in simulation.
- The expiry compare uses the decr16 result == 0 and does not use a separate comparator on count.

## Timing

- Reset values: count = 0, tc = 0, busy = 0, state IDLE. ld_ready = ~abort. Handshakes while rst_n is low are ignored.
- Reset mid-RUN asynchronously clears count, tc and busy without waiting for a clock edge.
- Load-to-expiry latency with en held high: accept at edge k gives count = N after edge k, 0 after edge k+N, and tc high in the cycle following edge k+N.
- Each low-en cycle in RUN delays expiry by exactly one cycle.
- tc is high for exactly one cycle per expiry. Back-to-back auto-reload expiries are N cycles apart. With N = 1, tc is high continuously while en = 1.
- A load accepted in DONE in the same cycle tc is high is legal. The next cycle shows the new count and tc = 0, or tc = 1 again if the new value is 0.

## Structure

- Package dcnt_pkg holds:
  - WIDTH = 16 and NIBBLES = 4
  - the state enum typedef (IDLE, RUN, DONE)
- Sub-module decr16 is purely combinational: in[15:0], out[15:0], bw.
  - It is built from four 4-bit decr4 slices.
  - Nibble j outputs its decremented value when all lower nibbles are zero; otherwise it passes its input through unchanged.
  - bw is the AND of the four all-zero nibble flags.
- dcnt16 contains the FSM, count, reload_q, auto_q, tc register and the handshake logic.

## Test plan

- One-shot: load 5, en = 1 → count 5,4,3,2,1,0; tc high exactly once, in the cycle count first reads 0; ld_ready low for 5 cycles, then high (DONE).
- Borrow chain: load 0x1000 → count 0x0FFF after the first enabled edge. Load 0x0100 → 0x00FF. decr16 exhaustively: out == in - 1 mod 2^16, and bw = 1 only for in = 0.
- Auto-reload: load 3 with ld_auto = 1 → count 3,2,1,3,2,1,…; tc every 3rd cycle; ld_ready stays low. abort → IDLE, count 0. Load 0 with ld_auto = 1 → one-shot, tc once.
- Pause: load 4, drop en for 2 cycles after the first decrement → count holds at 3; tc arrives 2 cycles later than the en-high run (6 cycles after accept).
- Collisions:
  - abort asserted in the expiry cycle → no tc, count 0, IDLE.
  - ld_valid with abort → not accepted.
  - Load 7 accepted in the DONE/tc cycle → count 7, tc drops.
- Reset: assert rst_n low mid-RUN between clock edges → count = 0, busy = 0, tc = 0 immediately. After release, ld_ready = 1 and a fresh load of 2 expires after 2 cycles.
